// File: rtl/branch_sequencer.sv
// Sequences the Mini SRC "br" instruction through T3..T6 after the main FSM hands off at T2.
// Strobes are decoded from the state register; statistics counters saturate at all-ones.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE  = 5'b10010,
  parameter bit         EARLY_EXIT = 1'b1,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             CON,
  output logic [1:0]       c2,
  output logic             Gra,
  output logic             Rout,
  output logic             CONin,
  output logic             PCout,
  output logic             Yin,
  output logic             Cout,
  output logic             ADD,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T3   = 3'd1;
  localparam logic [2:0] S_T4   = 3'd2;
  localparam logic [2:0] S_T5   = 3'd3;
  localparam logic [2:0] S_T6   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_reg, state_next;
  logic [1:0]       c2_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] taken_reg, ntaken_reg;
  logic             is_br, accept, inc_taken, inc_ntaken;
  logic             unused_ir_bits;

  assign unused_ir_bits = ^{ir[26:21], ir[18:0]};

  assign is_br  = (ir[31:27] == BR_OPCODE);
  assign accept = (state_reg == S_IDLE) && start && is_br;

  // CON is only meaningful in T4 (early-exit decision) and T6 (PC update).
  assign inc_taken  = (state_reg == S_T6) && CON;
  assign inc_ntaken = ((state_reg == S_T6) && !CON) ||
                      ((state_reg == S_T4) && EARLY_EXIT && !CON);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_T3;
      S_T3:    state_next = S_T4;
      S_T4:    state_next = (EARLY_EXIT && !CON) ? S_DONE : S_T5;
      S_T5:    state_next = S_T6;
      S_T6:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      c2_reg      <= 2'b00;
      illegal_reg <= 1'b0;
      taken_reg   <= '0;
      ntaken_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= (state_reg == S_IDLE) && start && !is_br;
      if (accept) c2_reg <= ir[20:19];
      if (inc_taken && (taken_reg != '1)) taken_reg <= taken_reg + CNT_ONE;
      if (inc_ntaken && (ntaken_reg != '1)) ntaken_reg <= ntaken_reg + CNT_ONE;
    end
  end

  assign c2         = c2_reg;
  assign Gra        = (state_reg == S_T3);
  assign Rout       = (state_reg == S_T3);
  assign CONin      = (state_reg == S_T3);
  assign PCout      = (state_reg == S_T4);
  assign Yin        = (state_reg == S_T4);
  assign Cout       = (state_reg == S_T5);
  assign ADD        = (state_reg == S_T5);
  assign Zin        = (state_reg == S_T5);
  assign Zlowout    = (state_reg == S_T6);
  // CON comes straight from the CON flip-flop, so PCin stays a registered-source path.
  assign PCin       = (state_reg == S_T6) && CON;
  assign busy       = (state_reg == S_T3) || (state_reg == S_T4) ||
                      (state_reg == S_T5) || (state_reg == S_T6);
  assign done       = (state_reg == S_DONE);
  assign illegal    = illegal_reg;
  assign taken_cnt  = taken_reg;
  assign ntaken_cnt = ntaken_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: one early-exit instance (16-bit counters) and one
// full-sequence instance (4-bit counters) share stimulus and a schedule-level model.
module tb_branch_sequencer;

  localparam logic [4:0] BR = 5'b10010;
  localparam int P_IDLE = 0, P_T3 = 1, P_T4 = 2, P_T5 = 3, P_T6 = 4, P_DONE = 5, P_ILL = 6;

  logic        clk = 1'b0;
  logic        reset, start, CON;
  logic [31:0] ir;

  logic [1:0]  c2_a, c2_b;
  logic        gra_a, rout_a, conin_a, pcout_a, yin_a, cout_a, add_a, zin_a, zlo_a, pcin_a, busy_a, done_a, ill_a;
  logic        gra_b, rout_b, conin_b, pcout_b, yin_b, cout_b, add_b, zin_b, zlo_b, pcin_b, busy_b, done_b, ill_b;
  logic [15:0] taken_a, ntaken_a;
  logic [3:0]  taken_b, ntaken_b;
  logic [12:0] obs_a, obs_b;

  int checks = 0;
  int failures = 0;
  int taken_m = 0, ntaken_m = 0;
  logic [1:0] c2_m = 2'b00;
  int txn_no = 0;

  always #5 clk = ~clk;

  branch_sequencer #(.BR_OPCODE(BR), .EARLY_EXIT(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .CON(CON), .c2(c2_a),
    .Gra(gra_a), .Rout(rout_a), .CONin(conin_a), .PCout(pcout_a), .Yin(yin_a),
    .Cout(cout_a), .ADD(add_a), .Zin(zin_a), .Zlowout(zlo_a), .PCin(pcin_a),
    .busy(busy_a), .done(done_a), .illegal(ill_a), .taken_cnt(taken_a), .ntaken_cnt(ntaken_a));

  branch_sequencer #(.BR_OPCODE(BR), .EARLY_EXIT(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .ir(ir), .CON(CON), .c2(c2_b),
    .Gra(gra_b), .Rout(rout_b), .CONin(conin_b), .PCout(pcout_b), .Yin(yin_b),
    .Cout(cout_b), .ADD(add_b), .Zin(zin_b), .Zlowout(zlo_b), .PCin(pcin_b),
    .busy(busy_b), .done(done_b), .illegal(ill_b), .taken_cnt(taken_b), .ntaken_cnt(ntaken_b));

  assign obs_a = {gra_a, rout_a, conin_a, pcout_a, yin_a, cout_a, add_a, zin_a, zlo_a, pcin_a, busy_a, done_a, ill_a};
  assign obs_b = {gra_b, rout_b, conin_b, pcout_b, yin_b, cout_b, add_b, zin_b, zlo_b, pcin_b, busy_b, done_b, ill_b};

  typedef struct {
    logic [4:0] op;
    logic [1:0] c2f;
    logic       con;
    int         inj;
    int         lat_ee1;
    int         lat_ee0;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Bit order: Gra Rout CONin PCout Yin Cout ADD Zin Zlowout PCin busy done illegal
  function automatic logic [12:0] strobes_of(int ph, logic con);
    case (ph)
      P_T3:    return 13'b1110000000100;
      P_T4:    return 13'b0001100000100;
      P_T5:    return 13'b0000011100100;
      P_T6:    return {9'b000000001, con, 3'b100};
      P_DONE:  return 13'b0000000000010;
      P_ILL:   return 13'b0000000000001;
      default: return 13'b0;
    endcase
  endfunction

  function automatic int phase_at(int i, bit legal, bit con, bit ee);
    int seq[$];
    if (!legal) return (i == 0) ? P_ILL : P_IDLE;
    seq = {P_T3, P_T4};
    if (!(ee && !con)) begin
      seq.push_back(P_T5);
      seq.push_back(P_T6);
    end
    seq.push_back(P_DONE);
    return (i < seq.size()) ? seq[i] : P_IDLE;
  endfunction

  function automatic int sat(int v, int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_counters();
    chk("taken_a", 32'(taken_a), 32'(sat(taken_m, 16)));
    chk("ntaken_a", 32'(ntaken_a), 32'(sat(ntaken_m, 16)));
    chk("taken_b", 32'(taken_b), 32'(sat(taken_m, 4)));
    chk("ntaken_b", 32'(ntaken_b), 32'(sat(ntaken_m, 4)));
  endtask

  // Entered #1 after a rising edge with both instances idle; leaves them idle.
  task automatic run_txn(input logic [4:0] op, input logic [1:0] c2f, input logic con,
                         input int inj, output int lat_a, output int lat_b);
    bit legal = (op == BR);
    lat_a = 0;
    lat_b = 0;
    ir = {op, 4'h5, 2'b00, c2f, 19'h1234};
    start = 1'b1;
    CON = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    ir = $urandom;
    if (legal) c2_m = c2f;
    for (int i = 0; i < 6; i++) begin
      if (i >= 1) CON = con;
      chk($sformatf("strobes_a[%0d]", i), 32'(obs_a), 32'(strobes_of(phase_at(i, legal, con, 1'b1), con)));
      chk($sformatf("strobes_b[%0d]", i), 32'(obs_b), 32'(strobes_of(phase_at(i, legal, con, 1'b0), con)));
      chk($sformatf("c2_a[%0d]", i), 32'(c2_a), 32'(c2_m));
      chk($sformatf("c2_b[%0d]", i), 32'(c2_b), 32'(c2_m));
      if (done_a && lat_a == 0) lat_a = i + 1;
      if (done_b && lat_b == 0) lat_b = i + 1;
      if (i == inj) begin
        start = 1'b1;
        ir = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (legal) begin
      if (con) taken_m++;
      else ntaken_m++;
    end
    check_counters();
    txn_no++;
    $display("txn %0d op=%b c2=%b con=%b inj=%0d lat_a=%0d lat_b=%0d taken=%0d ntaken=%0d",
             txn_no, op, c2f, con, inj, lat_a, lat_b, taken_a, ntaken_a);
  endtask

  initial begin
    vec_t vecs[6];
    int la, lb;

    vecs[0] = '{op: BR,       c2f: 2'b00, con: 1'b1, inj: -1, lat_ee1: 5, lat_ee0: 5};
    vecs[1] = '{op: BR,       c2f: 2'b01, con: 1'b0, inj: -1, lat_ee1: 3, lat_ee0: 5};
    vecs[2] = '{op: BR,       c2f: 2'b10, con: 1'b1, inj: 1,  lat_ee1: 5, lat_ee0: 5};
    vecs[3] = '{op: 5'b00011, c2f: 2'b00, con: 1'b1, inj: -1, lat_ee1: 0, lat_ee0: 0};
    vecs[4] = '{op: BR,       c2f: 2'b11, con: 1'b0, inj: 2,  lat_ee1: 3, lat_ee0: 5};
    vecs[5] = '{op: 5'b11111, c2f: 2'b10, con: 1'b0, inj: -1, lat_ee1: 0, lat_ee0: 0};

    reset = 1'b1;
    start = 1'b0;
    ir = 32'h0;
    CON = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_strobes_a", 32'(obs_a), 32'h0);
    chk("reset_strobes_b", 32'(obs_b), 32'h0);
    chk("reset_c2_a", 32'(c2_a), 32'h0);
    check_counters();

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].op, vecs[v].c2f, vecs[v].con, vecs[v].inj, la, lb);
      chk($sformatf("latency_a vec%0d", v), 32'(la), 32'(vecs[v].lat_ee1));
      chk($sformatf("latency_b vec%0d", v), 32'(lb), 32'(vecs[v].lat_ee0));
    end

    // Reset while both instances sit in T5.
    ir = {BR, 4'h2, 2'b00, 2'b10, 19'h0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    CON = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_in_t5_a", 32'(obs_a), 32'(strobes_of(P_T5, 1'b1)));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    taken_m = 0;
    ntaken_m = 0;
    c2_m = 2'b00;
    chk("midreset_strobes_a", 32'(obs_a), 32'h0);
    chk("midreset_strobes_b", 32'(obs_b), 32'h0);
    chk("midreset_c2_a", 32'(c2_a), 32'h0);
    chk("midreset_c2_b", 32'(c2_b), 32'h0);
    check_counters();
    @(posedge clk); #1;
    chk("midreset_idle_a", 32'(obs_a), 32'h0);
    run_txn(BR, 2'b11, 1'b1, -1, la, lb);
    chk("restart_latency_a", 32'(la), 32'd5);

    // Drive the 4-bit instance's taken counter into saturation.
    for (int k = 0; k < 18; k++) begin
      run_txn(BR, 2'(k), 1'b1, k % 3, la, lb);
    end
    chk("sat_taken_b", 32'(taken_b), 32'hF);

    for (int k = 0; k < 40; k++) begin
      logic [4:0] op;
      logic       con;
      int         inj;
      op  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : BR;
      con = 1'($urandom);
      inj = (op == BR) ? $urandom_range(0, 3) - 1 : -1;
      run_txn(op, 2'($urandom), con, inj, la, lb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
